// File: rtl/regfile_dump_pkg.sv
// Shared types for the register-file dump engine.
// REGFILE_DUMP_CSUM_EN adds a trailing XOR checksum beat.
package regfile_dump_pkg;

    localparam int REGADDR_W = 5;

    localparam logic [REGADDR_W-1:0] CSUM_IDX = 5'h1F;

`ifdef REGFILE_DUMP_CSUM_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        DONE  = 3'd3,
        CSUM  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/regfile_dump.sv
// Streams a range of register-file words out over a valid/ready port.
// Define REGFILE_DUMP_CSUM_EN to append an XOR checksum beat (idx 5'h1F).
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [REGADDR_W-1:0] first_reg,
    input  logic [REGADDR_W-1:0] last_reg,
    output logic [REGADDR_W-1:0] rd_addr,
    input  logic [N-1:0]         rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [REGADDR_W-1:0] out_idx,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    state_t state;
    state_t state_nx;

    logic [REGADDR_W-1:0] idx;
    logic [REGADDR_W-1:0] end_idx;
    logic [REGADDR_W-1:0] idx_inc;
    logic                 fire;
    logic                 last_beat;

`ifdef REGFILE_DUMP_CSUM_EN
    logic [N-1:0] csum;
    // fin marks the final register word; out_last is reserved for the checksum
    logic         fin;

    assign last_beat = fin;
    assign out_valid = (state == SEND) || (state == CSUM);
`else
    assign last_beat = out_last;
    assign out_valid = (state == SEND);
`endif

    assign fire    = out_valid && out_ready;
    assign idx_inc = (idx == REGADDR_W'(NREG - 1)) ? '0 : idx + 1'b1;
    assign rd_addr = idx;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = FETCH;
            end
            FETCH: state_nx = SEND;
            SEND: begin
                if (fire) begin
`ifdef REGFILE_DUMP_CSUM_EN
                    state_nx = last_beat ? CSUM : FETCH;
`else
                    state_nx = last_beat ? DONE : FETCH;
`endif
                end
            end
`ifdef REGFILE_DUMP_CSUM_EN
            CSUM: begin
                if (fire) state_nx = DONE;
            end
`endif
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            end_idx  <= '0;
            out_data <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
            csum     <= '0;
            fin      <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= first_reg;
                        end_idx <= last_reg;
`ifdef REGFILE_DUMP_CSUM_EN
                        csum    <= '0;
`endif
                    end
                end
                FETCH: begin
                    out_data <= rd_data;
                    out_idx  <= idx;
`ifdef REGFILE_DUMP_CSUM_EN
                    out_last <= 1'b0;
                    fin      <= (idx == end_idx);
                    csum     <= csum ^ rd_data;
`else
                    out_last <= (idx == end_idx);
`endif
                end
                SEND: begin
                    if (fire) begin
                        if (!last_beat) begin
                            idx <= idx_inc;
                        end
`ifdef REGFILE_DUMP_CSUM_EN
                        else begin
                            out_data <= csum;
                            out_idx  <= CSUM_IDX;
                            out_last <= 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter N, default 32, data width of one register word.
REQ-002 Parameter NREG, default 32, number of registers addressable; address width 5 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 first_reg  input  5  first register index of the dump; sampled with start.
REQ-007 last_reg  input  5  last register index of the dump; sampled with start.
REQ-008 rd_addr  output  5  address driven to register-file read port.
REQ-009 rd_data  input  N  combinational read data from register-file read port.
REQ-010 out_valid  output  1  output beat valid.
REQ-011 out_ready  input  1  downstream accepts beat.
REQ-012 out_data  output  N  beat payload.
REQ-013 out_idx  output  5  register index of current beat.
REQ-014 out_last  output  1  marks final beat of the dump.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after final beat accepted.

Function
REQ-017 FSM states IDLE, FETCH, SEND, DONE; encoding from shared package.
REQ-018 IDLE: start=1 -> latch first_reg into idx, last_reg into end_idx, go FETCH; start=0 -> stay.
REQ-019 rd_addr = idx in all states.
REQ-020 FETCH: capture rd_data into out_data, idx into out_idx, set out_last = (idx == end_idx), go SEND; lasts exactly one cycle.
REQ-021 SEND: out_valid=1; out_data/out_idx/out_last held stable until out_valid && out_ready.
REQ-022 SEND handshake with out_last=0: idx = idx+1 modulo 32, go FETCH.
REQ-023 SEND handshake with out_last=1: go DONE (or CSUM, see Configuration).
REQ-024 DONE: done=1 for one cycle, go IDLE.
REQ-025 Latency: start in cycle 0 -> out_valid first high in cycle 2; sustained rate one beat per 2 cycles with out_ready=1.
REQ-026 first_reg > last_reg: index wraps 31->0; beat count = 32 - first + last + 1.
REQ-027 first_reg == last_reg: exactly one beat, out_last=1.
REQ-028 start while busy: ignored, no effect on current dump.
REQ-029 out_ready asserted outside SEND: no effect.
REQ-030 Register contents changing while SEND holds: out_data does not change (value fixed at FETCH).

Reset
REQ-031 rst high -> immediately IDLE, idx=0, end_idx=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, csum=0.
REQ-032 rst mid-dump aborts it; no done pulse; next dump requires new start after rst deasserts.

Configuration
REQ-033 Macro REGFILE_DUMP_CSUM_EN defined: after final register beat, extra state CSUM sends one beat out_data = XOR of all dumped words, out_idx=5'h1F, out_last=1; register beats then carry out_last=0.
REQ-034 Macro REGFILE_DUMP_CSUM_EN undefined: no CSUM state, no checksum register, behaviour as REQ-017..REQ-030.

Structure
REQ-035 Shared package holds FSM state typedef and REGADDR_W=5 constant.
REQ-036 Single module, no sub-module; index counter and checksum inline.

Verification
REQ-037 Registers preset x1=0x11111111, x2=0x22222222; start first=1 last=2, out_ready=1 -> beats (1,0x11111111,last0),(2,0x22222222,last1), done pulse, total 6 cycles start-to-done.
REQ-038 first=30 last=1 -> beats idx 30,31,0,1 in order, out_last only on idx 1.
REQ-039 first=last=5, out_ready low 4 cycles in SEND -> out_valid and data stable all 4 cycles, single beat accepted, done once.
REQ-040 start pulsed again during dump first=0 last=3 -> still exactly 4 beats, no restart.
REQ-041 rst asserted during SEND of second beat -> out_valid, busy drop same cycle (async), no done.
REQ-042 With REGFILE_DUMP_CSUM_EN, dump x1..x2 as REQ-037 -> third beat out_data=0x33333333, out_idx=0x1F, out_last=1.
